shared_adder_arbiter: RTL and testbench

//  Shares one WIDTH-bit adder among NUM_REQ requesters (e.g. PC+4, branch

---
 rtl/adder_arb_pkg.sv | 26 ++
 rtl/shared_adder_arbiter_if.sv | 34 +++
 rtl/shared_adder_arbiter_rr_arbiter.sv | 40 ++++
 rtl/shared_adder_arbiter.sv | 81 ++++++++
 tb/tb_shared_adder_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin shared adder: id width helper and
// default-configuration operand/response records.
package adder_arb_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_NUM_REQ = 4;

    // Requester id width; never narrower than one bit.
    function automatic int id_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    localparam int DEFAULT_ID_W = id_w(DEFAULT_NUM_REQ);

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
    } operand_pair_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] result;
        logic                     carry;
        logic [DEFAULT_ID_W-1:0]  id;
    } rsp_t;

endpackage

// File: rtl/shared_adder_arbiter_if.sv
// Request/response bundle between requesters, the shared adder and its consumer.
import adder_arb_pkg::*;

// Both sides use valid/ready: a transfer happens on a clock edge where valid
// and ready are both high; valid must not wait for ready, and payload stays
// stable while valid is high and ready is low.
interface shared_adder_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_operand_a;
    logic [NUM_REQ*WIDTH-1:0] req_operand_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_carry;
    logic [ID_W-1:0]          rsp_id;
    logic [ID_W-1:0]          dbg_rr_ptr;

    modport slave (
        input  req_valid, req_operand_a, req_operand_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id, dbg_rr_ptr
    );

    modport master (
        output req_valid, req_operand_a, req_operand_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_id, dbg_rr_ptr
    );

endinterface

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after rr_ptr.
import adder_arb_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [id_w(NUM_REQ)-1:0]    rr_ptr,
    input  logic                        enable,
    output logic [NUM_REQ-1:0]          grant,
    output logic [id_w(NUM_REQ)-1:0]    grant_idx,
    output logic                        grant_valid
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [ID_W:0]   pos;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = '0;
        idx         = '0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // Extra bit keeps rr_ptr + k from overflowing before the wrap.
                pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
                if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
                idx = pos[ID_W-1:0];
                if (!grant_valid && req[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// One adder shared by NUM_REQ requesters; round-robin grant, one-cycle latency,
// single-entry tagged result register that refills while draining.
import adder_arb_pkg::*;

module shared_adder_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    shared_adder_arbiter_if.slave bus
);
    localparam int ID_W = id_w(NUM_REQ);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t              pairs [NUM_REQ];
    pair_t              sel;
    logic [WIDTH:0]     sum;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;
    logic               slot_free;
    logic [ID_W-1:0]    next_ptr;

    logic               rsp_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    rr_ptr_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign pairs[i] = {bus.req_operand_a[i*WIDTH +: WIDTH],
                           bus.req_operand_b[i*WIDTH +: WIDTH]};
    end

    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    // reset_n gates the grant so no requester sees ready while in reset.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (bus.req_valid),
        .rr_ptr      (rr_ptr_q),
        .enable      (slot_free && reset_n),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (accept)
    );

    assign sel      = pairs[grant_idx];
    assign sum      = {1'b0, sel.a} + {1'b0, sel.b};
    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            result_q    <= sum[WIDTH-1:0];
            carry_q     <= sum[WIDTH];
            id_q        <= grant_idx;
            rr_ptr_q    <= next_ptr;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_id     = id_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed and constrained-random checks of the shared adder arbiter.
import adder_arb_pkg::*;

module tb_shared_adder_arbiter;
  localparam int W  = DEFAULT_WIDTH;
  localparam int N  = DEFAULT_NUM_REQ;
  localparam int EW = $bits(rsp_t);

  logic clock;
  logic reset_n;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int checks;
  int failures;

  shared_adder_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  shared_adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.req_operand_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign bus.req_operand_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] r, input logic c, input logic [DEFAULT_ID_W-1:0] id);
    exp_q.push_back({r, c, id});
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got %0h id %0d with empty queue", bus.rsp_result, bus.rsp_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", {bus.rsp_result, bus.rsp_carry, bus.rsp_id}, mon_e);
      end
    end
  end

  // driver
  int m_ptr;
  logic m_valid;
  logic [N-1:0] eg;
  logic gv;
  int g;
  int last_g;
  logic last_gv;
  logic [W:0] s;

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    reset_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_result", bus.rsp_result, 0);
    check("rst_carry", bus.rsp_carry, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_rr_ptr", bus.dbg_rr_ptr, 0);
    bus.req_valid = '0;
    reset_n = 1'b1;
    cyc();

    // single request from requester 1
    op_a[1] = 5; op_b[1] = 7;
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    #1;
    check("single_ready", bus.req_ready, 4'b0010);
    push(12, 1'b0, 1);
    cyc();
    bus.req_valid = '0;
    #1;
    check("single_valid", bus.rsp_valid, 1);
    check("single_result", bus.rsp_result, 12);
    check("single_carry", bus.rsp_carry, 0);
    check("single_id", bus.rsp_id, 1);
    check("single_rr_ptr", bus.dbg_rr_ptr, 2);
    cyc();

    // hold a result, then reset asynchronously; held result must vanish
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    check("hold_ready", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    #1;
    check("hold_valid", bus.rsp_valid, 1);
    #1;
    bus.req_valid = 4'hF;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", bus.rsp_valid, 0);
    check("async_rst_ready", bus.req_ready, 0);
    check("async_rst_ptr", bus.dbg_rr_ptr, 0);
    @(posedge clock);
    cyc();

    // round-robin with all four requesters continuously valid
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'(i + 1);
      op_b[i] = W'(10 * (i + 1));
    end
    bus.rsp_ready = 1'b1;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", bus.req_ready, 4'b0001 << (k % 4));
      check("rr_valid", bus.rsp_valid, (k > 0) ? 1 : 0);
      push(W'(11 * ((k % 4) + 1)), 1'b0, DEFAULT_ID_W'(k % 4));
      cyc();
    end

    // backpressure with requester 2 waiting
    bus.rsp_ready = 1'b0;
    op_a[2] = 100; op_b[2] = 23;
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", bus.req_ready, 0);
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_result", bus.rsp_result, 11);
      check("bp_id", bus.rsp_id, 0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.req_ready, 4'b0100);
    push(123, 1'b0, 2);
    cyc();
    bus.req_valid = '0;
    #1;
    check("bp_next_valid", bus.rsp_valid, 1);
    check("bp_next_result", bus.rsp_result, 123);
    check("bp_next_id", bus.rsp_id, 2);

    // overflow wrap then zero operands
    op_a[3] = 32'hFFFF_FFFF; op_b[3] = 32'h2;
    bus.req_valid = 4'b1000;
    #1;
    check("wrap_ready", bus.req_ready, 4'b1000);
    push(1, 1'b1, 3);
    cyc();
    op_a[0] = 0; op_b[0] = 0;
    bus.req_valid = 4'b0001;
    #1;
    check("wrap_result", bus.rsp_result, 1);
    check("wrap_carry", bus.rsp_carry, 1);
    check("zero_ready", bus.req_ready, 4'b0001);
    push(0, 1'b0, 0);
    cyc();
    bus.req_valid = '0;
    #1;
    check("zero_result", bus.rsp_result, 0);
    check("zero_carry", bus.rsp_carry, 0);

    // fairness: requester 0 hogging, requester 3 appears once
    op_a[0] = 7; op_b[0] = 8;
    op_a[3] = 32'h10; op_b[3] = 32'h20;
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("fair_hog_ready", bus.req_ready, 4'b0001);
      push(15, 1'b0, 0);
      cyc();
    end
    bus.req_valid = 4'b1001;
    #1;
    check("fair_req3_ready", bus.req_ready, 4'b1000);
    push(32'h30, 1'b0, 3);
    cyc();
    bus.req_valid = 4'b0001;
    #1;
    check("fair_back_ready", bus.req_ready, 4'b0001);
    push(15, 1'b0, 0);
    cyc();
    bus.req_valid = '0;
    cyc();
    cyc();

    // random traffic against a reference round-robin model
    m_ptr = 1;
    m_valid = 1'b0;
    last_gv = 1'b0;
    last_g = 0;
    for (int c = 0; c < 300; c++) begin
      if (last_gv) bus.req_valid[last_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          op_a[i] = $urandom;
          op_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rand_valid", bus.rsp_valid, m_valid);
      eg = '0;
      gv = 1'b0;
      g = 0;
      if (!m_valid || bus.rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          if (!gv && bus.req_valid[(m_ptr + k) % N]) begin
            gv = 1'b1;
            g = (m_ptr + k) % N;
            eg[g] = 1'b1;
          end
        end
      end
      check("rand_ready", bus.req_ready, eg);
      if (gv) begin
        s = {1'b0, op_a[g]} + {1'b0, op_b[g]};
        push(s[W-1:0], s[W], DEFAULT_ID_W'(g));
        m_valid = 1'b1;
        m_ptr = (g + 1) % N;
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 1'b0;
      end
      last_gv = gv;
      last_g = g;
      cyc();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) cyc();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
